wordmux_arb: RTL and testbench

- Parametrised N-channel word multiplexer with valid/ready handshakes on every channel and one registered output stage.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Successor to the combinational word/bit muxes. Used where several producers share one datapath port, e.g. the register-file write-back bus and the memory request bus of the 16-bit CPU.

---
 rtl/wordmux_arb.sv | 152 +++++++++++++++
 tb/tb_wordmux_arb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wordmux_arb.sv
// wordmux_arb: N-channel valid/ready word multiplexer, fixed-select or round-robin, one output register.
// Optional packet lock in round-robin mode: define WORDMUX_ARB_LOCK_EN.
`default_nettype none

module wordmux_arb #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_mode,
  input  logic [SELW-1:0]        i_sel,
  input  logic [0:NCH-1]         i_valid,
  input  logic [0:NCH*WIDTH-1]   i_data,
`ifdef WORDMUX_ARB_LOCK_EN
  input  logic [0:NCH-1]         i_last,
  output logic                   o_locked,
`endif
  output logic [0:NCH-1]         o_ready,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [SELW-1:0]        o_chan,
  input  logic                   i_ready
);

  localparam logic [SELW-1:0] PTR_RST = SELW'(NCH - 1);

  logic [SELW-1:0]  ptr;
  logic             load;
  logic             fx_ok;
  logic             rr_ok;
  logic [SELW-1:0]  rr_idx;
  logic             grant_ok;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_word;
  logic             xfer;
  int               rr_dist;
  int               rr_best;

  assign load = !o_valid || i_ready;

  // Fixed mode: an out-of-range select simply matches no channel.
  always_comb begin
    fx_ok = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (i_sel == SELW'(k) && i_valid[k]) fx_ok = 1'b1;
    end
  end

  // Round-robin: pick the valid channel nearest after ptr, wrapping modulo NCH.
  always_comb begin
    rr_ok   = 1'b0;
    rr_idx  = '0;
    rr_best = NCH;
    rr_dist = 0;
    for (int k = 0; k < NCH; k++) begin
      rr_dist = k - int'(ptr) - 1;
      if (rr_dist < 0) rr_dist = rr_dist + NCH;
      if (i_valid[k] && rr_dist < rr_best) begin
        rr_best = rr_dist;
        rr_ok   = 1'b1;
        rr_idx  = SELW'(k);
      end
    end
  end

`ifdef WORDMUX_ARB_LOCK_EN
  logic            locked;
  logic [SELW-1:0] lock_ch;
  logic            lock_ok;
  logic            grant_last;

  assign o_locked = locked;

  always_comb begin
    lock_ok    = 1'b0;
    grant_last = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (lock_ch == SELW'(k)) lock_ok = i_valid[k];
      if (grant == SELW'(k)) grant_last = i_last[k];
    end
  end

  always_comb begin
    if (!i_mode) begin
      grant_ok = fx_ok;
      grant    = i_sel;
    end else if (locked) begin
      grant_ok = lock_ok;
      grant    = lock_ch;
    end else begin
      grant_ok = rr_ok;
      grant    = rr_idx;
    end
  end
`else
  always_comb begin
    if (!i_mode) begin
      grant_ok = fx_ok;
      grant    = i_sel;
    end else begin
      grant_ok = rr_ok;
      grant    = rr_idx;
    end
  end
`endif

  always_comb begin
    o_ready    = '0;
    grant_word = '0;
    for (int k = 0; k < NCH; k++) begin
      o_ready[k] = !i_rst && load && grant_ok && (grant == SELW'(k)) && i_valid[k];
      if (grant == SELW'(k)) grant_word = i_data[k*WIDTH +: WIDTH];
    end
  end

  assign xfer = |o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      ptr     <= PTR_RST;
`ifdef WORDMUX_ARB_LOCK_EN
      locked  <= 1'b0;
      lock_ch <= '0;
`endif
    end else begin
      if (xfer) begin
        o_valid <= 1'b1;
        o_data  <= grant_word;
        o_chan  <= grant;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (xfer && i_mode) ptr <= grant;
`ifdef WORDMUX_ARB_LOCK_EN
      if (!i_mode) begin
        locked <= 1'b0;
      end else if (xfer) begin
        locked  <= !grant_last;
        lock_ch <= grant;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wordmux_arb.sv
// tb_wordmux_arb: directed scoreboard bench for wordmux_arb (NCH=4, WIDTH=16).
`default_nettype none

module tb_wordmux_arb;

  localparam int W = 16;
  localparam int N = 4;
  localparam int S = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [S-1:0]     sel;
  logic [0:N-1]     valid;
  logic [0:N*W-1]   data;
  logic [0:N-1]     ready_o;
  logic             ovalid;
  logic [W-1:0]     odata;
  logic [S-1:0]     ochan;
  logic             dready;
`ifdef WORDMUX_ARB_LOCK_EN
  logic [0:N-1]     last;
  logic             olocked;
`endif

  wordmux_arb #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_mode  (mode),
    .i_sel   (sel),
    .i_valid (valid),
    .i_data  (data),
`ifdef WORDMUX_ARB_LOCK_EN
    .i_last  (last),
    .o_locked(olocked),
`endif
    .o_ready (ready_o),
    .o_valid (ovalid),
    .o_data  (odata),
    .o_chan  (ochan),
    .i_ready (dready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  logic [17:0] sb[$];
  logic [17:0] m_word;
  logic        m_ovalid;
  int          m_ptr;
  logic        m_locked;
  int          m_lock_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [W-1:0] w);
    data[k*W +: W] = w;
  endtask

  function automatic logic last_of(input int k);
`ifdef WORDMUX_ARB_LOCK_EN
    return last[k];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_grant(output logic ok, output int idx);
    ok  = 1'b0;
    idx = 0;
    if (!mode) begin
      if (int'(sel) < N && valid[int'(sel)]) begin
        ok  = 1'b1;
        idx = int'(sel);
      end
    end else if (m_locked) begin
      ok  = valid[m_lock_ch];
      idx = m_lock_ch;
    end else begin
      for (int off = 1; off <= N; off++) begin
        if (!ok && valid[(m_ptr + off) % N]) begin
          ok  = 1'b1;
          idx = (m_ptr + off) % N;
        end
      end
    end
  endtask

  // One clock: check o_ready before the edge, then the output register after it.
  task automatic cycle(input string tag);
    logic       ok;
    int         gi;
    logic [0:N-1] mask;
    logic       xf;
    logic       lst;
    #1;
    model_grant(ok, gi);
    mask = '0;
    if ((!m_ovalid || dready) && ok && valid[gi]) mask[gi] = 1'b1;
    xf  = |mask;
    lst = last_of(gi);
    check({tag, ".ready"}, 32'(mask), 32'(ready_o));
    if (xf) sb.push_back({data[gi*W +: W], S'(gi)});
    @(posedge clk);
    #1;
    if (xf) begin
      m_ovalid = 1'b1;
      m_word   = sb.pop_front();
      if (mode) m_ptr = gi;
    end else if (dready) begin
      m_ovalid = 1'b0;
    end
    if (!mode) m_locked = 1'b0;
    else if (xf) begin
      m_locked  = !lst;
      m_lock_ch = gi;
    end
    check({tag, ".valid"}, 32'(ovalid), 32'(m_ovalid));
    if (m_ovalid) begin
      check({tag, ".data"}, 32'(odata), 32'(m_word[17:2]));
      check({tag, ".chan"}, 32'(ochan), 32'(m_word[1:0]));
    end
`ifdef WORDMUX_ARB_LOCK_EN
    check({tag, ".locked"}, 32'(olocked), 32'(m_locked));
`endif
  endtask

  // Reset takes effect before any clock edge; held across one edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".rst_valid"}, 32'(ovalid), 32'd0);
    check({tag, ".rst_data"},  32'(odata),  32'd0);
    check({tag, ".rst_chan"},  32'(ochan),  32'd0);
    check({tag, ".rst_ready"}, 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_ovalid  = 1'b0;
    m_ptr     = N - 1;
    m_locked  = 1'b0;
    m_lock_ch = 0;
    sb.delete();
  endtask

  initial begin
    rst    = 1'b1;
    mode   = 1'b0;
    sel    = '0;
    valid  = '0;
    data   = '0;
    dready = 1'b1;
`ifdef WORDMUX_ARB_LOCK_EN
    last   = '1;
`endif
    #2;
    do_reset("init");

    // Fixed mode, channel 3
    sel = 2'd3; valid = 4'b0001; set_word(3, 16'hBEEF);
    cycle("fix3");
    check("fix3.exact_data", 32'(odata), 32'h0000BEEF);
    check("fix3.exact_chan", 32'(ochan), 32'd3);
    valid = 4'b1110;
    cycle("fix3_novalid");

    // Round-robin, all channels valid, no bubbles
    mode = 1'b1; valid = 4'b1111;
    for (int k = 0; k < N; k++) set_word(k, 16'h1000 + 16'(k));
    for (int i = 0; i < 6; i++) begin
      cycle("rr_all");
      check("rr_all.seq", 32'(ochan), 32'(i % N));
    end

    // Backpressure
    mode = 1'b0; sel = 2'd0; valid = 4'b1000; set_word(0, 16'h00AA);
    cycle("bp_load");
    dready = 1'b0; sel = 2'd1; valid = 4'b0100; set_word(1, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      check("bp_hold.data", 32'(odata), 32'h000000AA);
    end
    dready = 1'b1;
    cycle("bp_release");
    check("bp_release.data", 32'(odata), 32'h00005555);

    // Sparse round-robin with wrap
    mode = 1'b1; valid = 4'b0010; set_word(2, 16'h2222);
    cycle("rr_p2");
    valid = 4'b0100; set_word(1, 16'h1111);
    cycle("rr_ch1");
    check("rr_ch1.chan", 32'(ochan), 32'd1);
    valid = 4'b1001; set_word(0, 16'h0A0A); set_word(3, 16'h3B3B);
    cycle("rr_wrap_a");
    check("rr_wrap_a.chan", 32'(ochan), 32'd3);
    cycle("rr_wrap_b");
    check("rr_wrap_b.chan", 32'(ochan), 32'd0);

    // Reset mid-stream
    mode = 1'b0; sel = 2'd2; valid = 4'b0010; set_word(2, 16'h1234);
    cycle("mid_load");
    do_reset("mid");
    mode = 1'b1; valid = 4'b1111;
    cycle("post_rst");
    check("post_rst.chan", 32'(ochan), 32'd0);

`ifdef WORDMUX_ARB_LOCK_EN
    do_reset("lock");
    mode = 1'b1; valid = 4'b1100; set_word(0, 16'hC0C0); set_word(1, 16'hC1C1);
    last = 4'b0000;
    cycle("lock_w1");
    check("lock_w1.chan", 32'(ochan), 32'd0);
    check("lock_w1.lk", 32'(olocked), 32'd1);
    cycle("lock_w2");
    check("lock_w2.chan", 32'(ochan), 32'd0);
    last = 4'b1000;
    cycle("lock_w3");
    check("lock_w3.chan", 32'(ochan), 32'd0);
    check("lock_w3.lk", 32'(olocked), 32'd0);
    last = 4'b1111;
    cycle("lock_next");
    check("lock_next.chan", 32'(ochan), 32'd1);
`endif

    valid = '0;
    cycle("drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
